// File: rtl/l2_req_arbiter_pkg.sv
// Shared types and constants for the L1-to-L2 request arbiter.
package l2_req_arbiter_pkg;

    localparam int ID_W = 2;

    localparam logic [ID_W-1:0] REQ_L1D = 2'd0;
    localparam logic [ID_W-1:0] REQ_L1I = 2'd1;
    localparam logic [ID_W-1:0] REQ_PTW = 2'd2;

    localparam logic [3:0] MEM_LW = 4'd0;
    localparam logic [3:0] MEM_SW = 4'd1;

    typedef enum logic [1:0] {
        ARB_IDLE     = 2'd0,
        ARB_ISSUE    = 2'd1,
        ARB_WAIT_RSP = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  opcode;
    } mem_req_t;

endpackage

// File: rtl/l2_req_arbiter_rr_pick.sv
// Round-robin selector: first set request at or after the start index, wrapping.
module l2_req_arbiter_rr_pick
    import l2_req_arbiter_pkg::*;
#(
    parameter int N_REQ = 3
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  start,
    output logic             vld,
    output logic [ID_W-1:0]  idx
);

    always_comb begin
        int c;
        c   = 0;
        vld = 1'b0;
        idx = '0;
        // Walk from the farthest offset down so the nearest request is written last.
        for (int off = N_REQ - 1; off >= 0; off--) begin
            c = (int'(start) + off) % N_REQ;
            if (req[c]) begin
                vld = 1'b1;
                idx = ID_W'(c);
            end
        end
    end

endmodule

// File: rtl/l2_req_arbiter.sv
// Arbitrates L1-side requesters onto the single shared L2 request port, one transaction at a time.
module l2_req_arbiter
    import l2_req_arbiter_pkg::*;
#(
    parameter int N_REQ = 3,
    parameter int AW    = 32,
    parameter int DW    = 128
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ-1:0][AW-1:0]    req_addr,
    input  logic [N_REQ-1:0][3:0]       req_opcode,
    input  logic [DW-1:0]               req_store_data,
    output logic [N_REQ-1:0]            rsp_valid,
    input  logic                        flush_active,
    output logic                        l2_req_valid,
    input  logic                        l2_req_ack,
    output logic [AW-1:0]               l2_req_addr,
    output logic [3:0]                  l2_req_opcode,
    output logic [DW-1:0]               l2_req_store_data,
    input  logic                        l2_rsp_valid,
    output logic                        busy,
    output logic [ID_W-1:0]             gnt_id,
    output logic [N_REQ-1:0][31:0]      gnt_count
);

    arb_state_t         state, state_nxt;
    logic [N_REQ-1:0]   pending, req_vec, win_mask;
    logic [ID_W-1:0]    rr_ptr, win_idx;
    logic               pick_vld, grant;

    // Same-cycle pulses compete alongside already-latched requests.
    assign req_vec = pending | req_valid;

    l2_req_arbiter_rr_pick #(.N_REQ(N_REQ)) rr_pick (
        .req   (req_vec),
        .start (rr_ptr),
        .vld   (pick_vld),
        .idx   (win_idx)
    );

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        unique case (state)
            ARB_IDLE: begin
                if (!flush_active && pick_vld) begin
                    grant     = 1'b1;
                    state_nxt = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                if (l2_rsp_valid)    state_nxt = ARB_IDLE;
                else if (l2_req_ack) state_nxt = ARB_WAIT_RSP;
            end
            ARB_WAIT_RSP: begin
                if (l2_rsp_valid) state_nxt = ARB_IDLE;
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    assign busy         = (state != ARB_IDLE);
    assign l2_req_valid = (state == ARB_ISSUE);

    always_comb begin
        win_mask  = '0;
        rsp_valid = '0;
        for (int i = 0; i < N_REQ; i++) begin
            win_mask[i]  = grant && (win_idx == ID_W'(i));
            rsp_valid[i] = busy && l2_rsp_valid && (gnt_id == ID_W'(i));
        end
    end

    assign l2_req_addr       = req_addr[gnt_id];
    assign l2_req_opcode     = req_opcode[gnt_id];
    assign l2_req_store_data = req_store_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ARB_IDLE;
            pending   <= '0;
            rr_ptr    <= '0;
            gnt_id    <= '0;
            gnt_count <= '0;
        end else begin
            state   <= state_nxt;
            pending <= req_vec & ~win_mask;
            if (grant) begin
                gnt_id             <= win_idx;
                rr_ptr             <= (win_idx == ID_W'(N_REQ - 1)) ? '0 : win_idx + ID_W'(1);
                gnt_count[win_idx] <= gnt_count[win_idx] + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_l2_req_arbiter.sv
// Directed bench for l2_req_arbiter: handshake timing, round-robin order, absorb, flush, reset.
module tb_l2_req_arbiter;
    import l2_req_arbiter_pkg::*;

    localparam int N_REQ = 3;
    localparam int AW    = 32;
    localparam int DW    = 128;

    localparam logic [AW-1:0]   A0 = 32'h1000_0000;
    localparam logic [AW-1:0]   A1 = 32'h2000_0040;
    localparam logic [AW-1:0]   A2 = 32'h3000_0080;
    localparam logic [DW-1:0]   SD = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_CAFE_F00D;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [N_REQ-1:0]         req_valid;
    logic [N_REQ-1:0][AW-1:0] req_addr;
    logic [N_REQ-1:0][3:0]    req_opcode;
    logic [DW-1:0]            req_store_data;
    logic [N_REQ-1:0]         rsp_valid;
    logic                     flush_active;
    logic                     l2_req_valid, l2_req_ack, l2_rsp_valid, busy;
    logic [AW-1:0]            l2_req_addr;
    logic [3:0]               l2_req_opcode;
    logic [DW-1:0]            l2_req_store_data;
    logic [1:0]               gnt_id;
    logic [N_REQ-1:0][31:0]   gnt_count;

    int n_chk = 0;
    int n_err = 0;
    int hits;
    logic [AW-1:0] exp_addr [N_REQ];

    always #5 clk = ~clk;

    l2_req_arbiter #(.N_REQ(N_REQ), .AW(AW), .DW(DW)) dut (
        .clk               (clk),
        .reset             (reset),
        .req_valid         (req_valid),
        .req_addr          (req_addr),
        .req_opcode        (req_opcode),
        .req_store_data    (req_store_data),
        .rsp_valid         (rsp_valid),
        .flush_active      (flush_active),
        .l2_req_valid      (l2_req_valid),
        .l2_req_ack        (l2_req_ack),
        .l2_req_addr       (l2_req_addr),
        .l2_req_opcode     (l2_req_opcode),
        .l2_req_store_data (l2_req_store_data),
        .l2_rsp_valid      (l2_rsp_valid),
        .busy              (busy),
        .gnt_id            (gnt_id),
        .gnt_count         (gnt_count)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset        = 1'b0;
        req_valid    = '0;
        l2_req_ack   = 1'b0;
        l2_rsp_valid = 1'b1;
        flush_active = 1'b0;
        cyc();
        chk("rst_busy",   busy,         0);
        chk("rst_l2req",  l2_req_valid, 0);
        chk("rst_rsp",    rsp_valid,    0);
        chk("rst_gnt_id", gnt_id,       0);
        chk("rst_cnt0",   gnt_count[0], 0);
        l2_rsp_valid = 1'b0;
        cyc();
        reset = 1'b1;
        cyc();
    endtask

    initial begin
        req_addr[0] = A0; req_addr[1] = A1; req_addr[2] = A2;
        exp_addr[0] = A0; exp_addr[1] = A1; exp_addr[2] = A2;
        req_opcode[0] = MEM_SW; req_opcode[1] = MEM_LW; req_opcode[2] = MEM_LW;
        req_store_data = SD;

        // Single l1d transaction: pulse t, ack t+1, response t+4.
        do_reset();
        req_valid = 3'b001; #1;
        chk("t1_no_req_at_t", l2_req_valid, 0);
        cyc();
        req_valid = '0; l2_req_ack = 1'b1; #1;
        chk("t1_req_at_t1", l2_req_valid, 1);
        chk("t1_gnt_id",    gnt_id, 0);
        chk("t1_addr",      l2_req_addr, A0);
        chk("t1_opcode",    l2_req_opcode, MEM_SW);
        chk("t1_sd_lo",     l2_req_store_data[63:0], SD[63:0]);
        chk("t1_sd_hi",     l2_req_store_data[127:64], SD[127:64]);
        chk("t1_cnt0",      gnt_count[0], 1);
        cyc();
        l2_req_ack = 1'b0; #1;
        chk("t1_req_t2", l2_req_valid, 0);
        chk("t1_busy_t2", busy, 1);
        chk("t1_rsp_t2", rsp_valid, 0);
        cyc(); #1;
        chk("t1_req_t3", l2_req_valid, 0);
        cyc();
        l2_rsp_valid = 1'b1; #1;
        chk("t1_rsp_t4", rsp_valid, 3'b001);
        cyc(); #1;
        chk("t1_idle_t5", busy, 0);
        chk("t1_rsp_ignored_idle", rsp_valid, 0);
        l2_rsp_valid = 1'b0;

        // All three pulse together: order 0,1,2, then pointer back at 0.
        do_reset();
        req_valid = 3'b111;
        cyc();
        req_valid = '0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("rr_l2req", l2_req_valid, 1);
            chk("rr_gnt_id", gnt_id, 64'(k));
            chk("rr_addr", l2_req_addr, exp_addr[k]);
            l2_rsp_valid = 1'b1; #1;
            chk("rr_rsp", rsp_valid, 64'(1) << k);
            cyc();
            l2_rsp_valid = 1'b0; #1;
            chk("rr_idle_between", busy, 0);
            cyc();
        end
        chk("rr_stays_idle", busy, 0);
        chk("rr_cnt0", gnt_count[0], 1);
        chk("rr_cnt1", gnt_count[1], 1);
        chk("rr_cnt2", gnt_count[2], 1);
        req_valid = 3'b111;
        cyc();
        req_valid = '0; #1;
        chk("rr_ptr_wrapped", gnt_id, 0);

        // Duplicate l1i pulse while pending is absorbed.
        do_reset();
        req_valid = 3'b001;
        cyc();
        req_valid = 3'b010; #1;
        chk("abs_owner0", gnt_id, 0);
        cyc();
        req_valid = 3'b010;
        cyc();
        req_valid = '0; l2_rsp_valid = 1'b1; #1;
        chk("abs_rsp0", rsp_valid, 3'b001);
        cyc();
        l2_rsp_valid = 1'b0; #1;
        chk("abs_idle", busy, 0);
        cyc(); #1;
        chk("abs_l2req1", l2_req_valid, 1);
        chk("abs_gnt1", gnt_id, 1);
        l2_rsp_valid = 1'b1; #1;
        chk("abs_rsp1", rsp_valid, 3'b010);
        cyc();
        l2_rsp_valid = 1'b0;
        hits = 0;
        repeat (5) begin
            if (l2_req_valid || busy) hits++;
            cyc();
        end
        chk("abs_no_second_grant", hits, 0);
        chk("abs_cnt1", gnt_count[1], 1);

        // Flush holds off grants; pending l1i survives and wins once flush drops.
        do_reset();
        flush_active = 1'b1;
        req_valid = 3'b010;
        cyc();
        req_valid = '0;
        hits = 0;
        repeat (20) begin
            if (l2_req_valid || busy) hits++;
            cyc();
        end
        chk("fl_no_grant", hits, 0);
        flush_active = 1'b0;
        cyc(); #1;
        chk("fl_l2req", l2_req_valid, 1);
        chk("fl_gnt1", gnt_id, 1);
        chk("fl_addr", l2_req_addr, A1);
        l2_rsp_valid = 1'b1;
        cyc();
        l2_rsp_valid = 1'b0;

        // Ack and response together in ISSUE.
        req_valid = 3'b100;
        cyc();
        req_valid = '0; l2_req_ack = 1'b1; l2_rsp_valid = 1'b1; #1;
        chk("ar_l2req", l2_req_valid, 1);
        chk("ar_rsp", rsp_valid, 3'b100);
        cyc();
        l2_req_ack = 1'b0; #1;
        chk("ar_idle", busy, 0);
        chk("ar_single_pulse", rsp_valid, 0);
        l2_rsp_valid = 1'b0;

        // Reset in WAIT_RSP with ptw pending.
        req_valid = 3'b001;
        cyc();
        req_valid = 3'b100; l2_req_ack = 1'b1;
        cyc();
        req_valid = '0; l2_req_ack = 1'b0; #1;
        chk("mr_wait_busy", busy, 1);
        reset = 1'b0; l2_rsp_valid = 1'b1; #1;
        chk("mr_busy", busy, 0);
        chk("mr_l2req", l2_req_valid, 0);
        chk("mr_rsp", rsp_valid, 0);
        chk("mr_gnt_id", gnt_id, 0);
        chk("mr_cnt0", gnt_count[0], 0);
        chk("mr_cnt2", gnt_count[2], 0);
        cyc();
        l2_rsp_valid = 1'b0; reset = 1'b1;
        hits = 0;
        repeat (6) begin
            if (l2_req_valid || busy || (rsp_valid != 0)) hits++;
            cyc();
        end
        chk("mr_no_later_grant", hits, 0);
        chk("mr_cnt2_after", gnt_count[2], 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
